// File: rtl/rd_engine_run_ctrl.sv
// rd_engine_run_ctrl: run sequencer ahead of the AXI read master (start, loop, stop, first-error capture).
// Optional per-run watchdog in WAIT is compiled in when RD_RUN_CTRL_TIMEOUT_EN is defined.

module rd_engine_run_ctrl #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_start,
    input  logic                 reg_stop,
    input  logic [15:0]          reg_loop_count,
    input  logic [31:0]          reg_rd_number,
    input  logic [31:0]          reg_timeout,
    output logic                 engine_start_pulse,
    input  logic                 rd_done_pulse,
    input  logic [1:0]           rd_error,
    input  logic [63:0]          rd_error_info,
    output logic                 run_busy,
    output logic                 run_done_pulse,
    output logic [2:0]           run_status,
    output logic [63:0]          run_err_info,
    output logic [15:0]          loops_done,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 stop_q, stop_d;
    logic [15:0]          loops_q, loops_d;
    logic [2:0]           status_q, status_d;
    logic [63:0]          info_q, info_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [16:0]          loops_next;
    logic                 last_run;

`ifdef RD_RUN_CTRL_TIMEOUT_EN
    logic [31:0]          wd_q, wd_d;
    logic                 wd_expired;

    assign wd_expired = (reg_timeout != '0) && ((wd_q + 32'd1) >= reg_timeout);
`else
    logic                 unused_timeout;

    assign unused_timeout = ^reg_timeout;
`endif

    // 17-bit compare so a saturated loops_done can never alias a programmed count.
    assign loops_next = {1'b0, loops_q} + 17'd1;
    assign last_run   = (reg_loop_count != '0) && (loops_next == {1'b0, reg_loop_count});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stop_q   <= 1'b0;
            loops_q  <= '0;
            status_q <= '0;
            info_q   <= '0;
            cyc_q    <= '0;
            gap_q    <= '0;
`ifdef RD_RUN_CTRL_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stop_q   <= stop_d;
            loops_q  <= loops_d;
            status_q <= status_d;
            info_q   <= info_d;
            cyc_q    <= cyc_d;
            gap_q    <= gap_d;
`ifdef RD_RUN_CTRL_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        stop_d   = stop_q;
        loops_d  = loops_q;
        status_d = status_q;
        info_d   = info_q;
        cyc_d    = busy_q ? (cyc_q + CNT_WIDTH'(1)) : cyc_q;
        gap_d    = gap_q;
`ifdef RD_RUN_CTRL_TIMEOUT_EN
        wd_d     = wd_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (reg_start) begin
                    busy_d   = 1'b1;
                    stop_d   = reg_stop;
                    loops_d  = '0;
                    status_d = '0;
                    info_d   = '0;
                    cyc_d    = '0;
                    gap_d    = '0;
                    // A zero-burst start is never answered by the read master.
                    state_d  = (reg_rd_number == '0) ? S_FIN : S_LAUNCH;
                end
            end

            S_LAUNCH: begin
`ifdef RD_RUN_CTRL_TIMEOUT_EN
                wd_d = '0;
`endif
                if (reg_stop) begin
                    stop_d = 1'b1;
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (reg_stop) begin
                    stop_d = 1'b1;
                end
`ifdef RD_RUN_CTRL_TIMEOUT_EN
                wd_d = wd_q + 32'd1;
`endif
                if (rd_done_pulse) begin
                    if (loops_q != 16'hFFFF) begin
                        loops_d = loops_q + 16'd1;
                    end
                    if ((rd_error != 2'b00) && (status_q == 3'b000)) begin
                        status_d = {1'b0, rd_error};
                        info_d   = rd_error_info;
                        state_d  = S_FIN;
                    end else if (stop_q || reg_stop || last_run) begin
                        state_d = S_FIN;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
`ifdef RD_RUN_CTRL_TIMEOUT_EN
                else if (wd_expired) begin
                    if (status_q == 3'b000) begin
                        status_d = 3'b100;
                    end
                    state_d = S_FIN;
                end
`endif
            end

            S_GAP: begin
                if (reg_stop) begin
                    state_d = S_FIN;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_LAUNCH;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign engine_start_pulse = (state_q == S_LAUNCH);
    assign run_busy           = busy_q;
    assign run_done_pulse     = done_q;
    assign run_status         = status_q;
    assign run_err_info       = info_q;
    assign loops_done         = loops_q;
    assign cycle_count        = cyc_q;

endmodule
